// File: rtl/peak_batch_scheduler.sv
// rtl/peak_batch_scheduler.sv - front-end batch sequencer for the shared FFT peak detector
//
// Admits one complete FFT batch at a time and forwards it to the peak detector
// with one cycle of latency. While the detector is working on a batch (or a
// batch is being passed through), new batches are dropped. Malformed batches
// are aborted by sending the detector a bare end-of-packet marker. A timer
// bounds how long the scheduler waits for the detector's result record.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   enable            high: new batches may be admitted
//   in_sop/in_eop/in_valid/in_re/in_im
//                     FFT output stream (one re/im entry per valid cycle)
//   pd_sop/pd_eop/pd_valid/pd_re/pd_im
//                     registered stream into the detector sink
//   res_valid/res_eop detector result beats
//   busy              high while a batch is passing through or awaiting results
//   frame_done        pulse: a good result record completed
//   err_len           pulse: malformed batch or malformed result record
//   err_timeout       pulse: detector did not finish in time
//   frame_cnt/drop_cnt saturating completed-frame and dropped-batch counters

module peak_batch_scheduler #(
  parameter int BATCH_SIZE = 1024,
  parameter int DATA_WIDTH = 16,
  parameter int NPEAKS     = 4,
  parameter int TIMEOUT    = 4096
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  in_sop,
  input  logic                  in_eop,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_re,
  input  logic [DATA_WIDTH-1:0] in_im,
  output logic                  pd_sop,
  output logic                  pd_eop,
  output logic                  pd_valid,
  output logic [DATA_WIDTH-1:0] pd_re,
  output logic [DATA_WIDTH-1:0] pd_im,
  input  logic                  res_valid,
  input  logic                  res_eop,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  err_len,
  output logic                  err_timeout,
  output logic [15:0]           frame_cnt,
  output logic [15:0]           drop_cnt
);

  localparam int CNT_W  = $clog2(BATCH_SIZE) + 2;
  localparam int TMR_W  = $clog2(TIMEOUT) + 1;
  localparam int BEAT_W = $clog2(NPEAKS + 1) + 1;

  localparam logic [CNT_W-1:0]  BS_FULL = CNT_W'(BATCH_SIZE);
  localparam logic [CNT_W-1:0]  BS_M1   = CNT_W'(BATCH_SIZE - 1);
  localparam logic [TMR_W-1:0]  TMO_M1  = TMR_W'(TIMEOUT - 1);
  localparam logic [BEAT_W-1:0] NP_M1   = BEAT_W'(NPEAKS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PASS = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [TMR_W-1:0]      timer_q, timer_d;
  logic [BEAT_W-1:0]     beats_q, beats_d;
  logic                  pd_sop_q, pd_sop_d;
  logic                  pd_eop_q, pd_eop_d;
  logic                  pd_valid_q, pd_valid_d;
  logic [DATA_WIDTH-1:0] pd_re_q, pd_re_d;
  logic [DATA_WIDTH-1:0] pd_im_q, pd_im_d;
  logic                  busy_q, busy_d;
  logic                  frame_done_q, frame_done_d;
  logic                  err_len_q, err_len_d;
  logic                  err_timeout_q, err_timeout_d;
  logic [15:0]           frame_cnt_q, frame_cnt_d;
  logic [15:0]           drop_cnt_q, drop_cnt_d;

  // Per-cycle decisions, applied uniformly after the state case.
  logic fwd;
  logic abort;
  logic drop_inc;
  logic frame_inc;
  logic to_wait;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    timer_d       = timer_q;
    beats_d       = beats_q;
    pd_sop_d      = 1'b0;
    pd_eop_d      = 1'b0;
    pd_valid_d    = 1'b0;
    pd_re_d       = pd_re_q;
    pd_im_d       = pd_im_q;
    frame_done_d  = 1'b0;
    err_len_d     = 1'b0;
    err_timeout_d = 1'b0;
    fwd           = 1'b0;
    abort         = 1'b0;
    drop_inc      = 1'b0;
    frame_inc     = 1'b0;
    to_wait       = 1'b0;

    // Skipping the remainder of a dropped batch needs no extra state: only an
    // in_sop can start a batch, and non-sop entries are ignored outside PASS.
    unique case (state_q)
      S_IDLE: begin
        if (in_valid && in_sop) begin
          if (!enable) begin
            drop_inc = 1'b1;
          end else if (in_eop && (BS_M1 != '0)) begin
            // Single-entry batch when batches are longer than one entry.
            abort = 1'b1;
          end else begin
            fwd   = 1'b1;
            cnt_d = CNT_W'(1);
            if (in_eop) begin
              to_wait = 1'b1;
            end else begin
              state_d = S_PASS;
            end
          end
        end
      end

      S_PASS: begin
        if (in_valid) begin
          if (in_sop) begin
            // A new batch overlapping the current one: abort the current
            // batch and treat the newcomer as dropped.
            abort    = 1'b1;
            drop_inc = 1'b1;
          end else if (in_eop) begin
            if (cnt_q == BS_M1) begin
              fwd     = 1'b1;
              to_wait = 1'b1;
            end else begin
              abort = 1'b1;
            end
          end else if (cnt_q == BS_FULL) begin
            // A full batch has been forwarded and more entries keep coming.
            abort = 1'b1;
          end else begin
            fwd   = 1'b1;
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      S_WAIT: begin
        if (in_valid && in_sop) begin
          drop_inc = 1'b1;
        end
        // A closing result beat takes priority over an expiring timer.
        if (res_valid && res_eop) begin
          if (beats_q == NP_M1) begin
            frame_done_d = 1'b1;
            frame_inc    = 1'b1;
          end else begin
            err_len_d = 1'b1;
          end
          state_d = S_IDLE;
        end else if (timer_q == TMO_M1) begin
          err_timeout_d = 1'b1;
          state_d       = S_IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
          if (res_valid && (beats_q != '1)) begin
            beats_d = beats_q + BEAT_W'(1);
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (fwd) begin
      pd_valid_d = 1'b1;
      pd_sop_d   = in_sop;
      pd_eop_d   = in_eop;
      pd_re_d    = in_re;
      pd_im_d    = in_im;
    end

    if (to_wait) begin
      state_d = S_WAIT;
      cnt_d   = '0;
      timer_d = '0;
      beats_d = '0;
    end

    // A bare end-of-packet marker flushes the detector's partial batch.
    if (abort) begin
      pd_eop_d  = 1'b1;
      err_len_d = 1'b1;
      state_d   = S_IDLE;
      cnt_d     = '0;
    end

    frame_cnt_d = frame_cnt_q;
    if (frame_inc && (frame_cnt_q != 16'hFFFF)) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end

    drop_cnt_d = drop_cnt_q;
    if (drop_inc && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end

    busy_d = (state_d == S_PASS) || (state_d == S_WAIT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      timer_q       <= '0;
      beats_q       <= '0;
      pd_sop_q      <= 1'b0;
      pd_eop_q      <= 1'b0;
      pd_valid_q    <= 1'b0;
      pd_re_q       <= '0;
      pd_im_q       <= '0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      err_len_q     <= 1'b0;
      err_timeout_q <= 1'b0;
      frame_cnt_q   <= '0;
      drop_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      timer_q       <= timer_d;
      beats_q       <= beats_d;
      pd_sop_q      <= pd_sop_d;
      pd_eop_q      <= pd_eop_d;
      pd_valid_q    <= pd_valid_d;
      pd_re_q       <= pd_re_d;
      pd_im_q       <= pd_im_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
      err_len_q     <= err_len_d;
      err_timeout_q <= err_timeout_d;
      frame_cnt_q   <= frame_cnt_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  assign pd_sop      = pd_sop_q;
  assign pd_eop      = pd_eop_q;
  assign pd_valid    = pd_valid_q;
  assign pd_re       = pd_re_q;
  assign pd_im       = pd_im_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign err_len     = err_len_q;
  assign err_timeout = err_timeout_q;
  assign frame_cnt   = frame_cnt_q;
  assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_peak_batch_scheduler.sv
// tb/tb_peak_batch_scheduler.sv - self-checking bench for peak_batch_scheduler
module tb_peak_batch_scheduler;

  localparam int BS  = 8;
  localparam int DW  = 16;
  localparam int NP  = 4;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b1;
  logic          in_sop = 1'b0;
  logic          in_eop = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_re = '0;
  logic [DW-1:0] in_im = '0;
  logic          pd_sop, pd_eop, pd_valid;
  logic [DW-1:0] pd_re, pd_im;
  logic          res_valid = 1'b0;
  logic          res_eop = 1'b0;
  logic          busy, frame_done, err_len, err_timeout;
  logic [15:0]   frame_cnt, drop_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  peak_batch_scheduler #(
    .BATCH_SIZE(BS), .DATA_WIDTH(DW), .NPEAKS(NP), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .in_sop(in_sop), .in_eop(in_eop), .in_valid(in_valid),
    .in_re(in_re), .in_im(in_im),
    .pd_sop(pd_sop), .pd_eop(pd_eop), .pd_valid(pd_valid),
    .pd_re(pd_re), .pd_im(pd_im),
    .res_valid(res_valid), .res_eop(res_eop),
    .busy(busy), .frame_done(frame_done), .err_len(err_len),
    .err_timeout(err_timeout), .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
  );

  // Behavioural model: a batch in flight is described by how many entries
  // have been forwarded (0 = none), a waiting flag and the wait age.
  int            m_fwd_entries = 0;
  bit            m_waiting = 0;
  int            m_age = 0;
  int            m_beats = 0;
  bit            e_valid = 0, e_sop = 0, e_eop = 0, e_busy = 0;
  bit            e_fd = 0, e_el = 0, e_et = 0;
  logic [DW-1:0] e_re = '0, e_im = '0;
  int            e_frame = 0, e_drop = 0;

  always @(posedge clk) begin
    e_valid = 0; e_sop = 0; e_eop = 0; e_fd = 0; e_el = 0; e_et = 0;
    if (reset) begin
      m_fwd_entries = 0; m_waiting = 0; m_age = 0; m_beats = 0;
      e_re = '0; e_im = '0; e_frame = 0; e_drop = 0;
    end else if (m_waiting) begin
      if (in_valid && in_sop && e_drop < 65535) e_drop = e_drop + 1;
      if (res_valid && res_eop) begin
        if (m_beats + 1 == NP) begin
          e_fd = 1;
          if (e_frame < 65535) e_frame = e_frame + 1;
        end else begin
          e_el = 1;
        end
        m_waiting = 0;
      end else if (m_age == TMO - 1) begin
        e_et = 1;
        m_waiting = 0;
      end else begin
        m_age = m_age + 1;
        if (res_valid) m_beats = m_beats + 1;
      end
    end else if (m_fwd_entries > 0) begin
      if (in_valid) begin
        if (in_sop || (in_eop && m_fwd_entries + 1 != BS) || (!in_eop && m_fwd_entries == BS)) begin
          e_eop = 1; e_el = 1; m_fwd_entries = 0;
          if (in_sop && e_drop < 65535) e_drop = e_drop + 1;
        end else begin
          e_valid = 1; e_eop = in_eop; e_re = in_re; e_im = in_im;
          m_fwd_entries = m_fwd_entries + 1;
          if (in_eop) begin
            m_fwd_entries = 0; m_waiting = 1; m_age = 0; m_beats = 0;
          end
        end
      end
    end else if (in_valid && in_sop) begin
      if (!enable) begin
        if (e_drop < 65535) e_drop = e_drop + 1;
      end else if (in_eop && BS != 1) begin
        e_eop = 1; e_el = 1;
      end else begin
        e_valid = 1; e_sop = 1; e_eop = in_eop; e_re = in_re; e_im = in_im;
        if (in_eop) begin
          m_waiting = 1; m_age = 0; m_beats = 0;
        end else begin
          m_fwd_entries = 1;
        end
      end
    end
    e_busy = m_waiting || (m_fwd_entries > 0);
  end

  // Observation counters, sampled on the falling edge.
  int cyc = 0;
  int c_fwd = 0, c_abort = 0, c_el = 0, c_fd = 0, c_et = 0;
  int t_eop = 0, t_to = -1;
  logic [70:0] act_v, exp_v;

  task automatic cycle_compare();
    act_v = {pd_valid, pd_sop, pd_eop, busy, frame_done, err_len, err_timeout,
             pd_re, pd_im, frame_cnt, drop_cnt};
    exp_v = {e_valid, e_sop, e_eop, e_busy, e_fd, e_el, e_et,
             e_re, e_im, 16'(e_frame), 16'(e_drop)};
    tests = tests + 1;
    if (act_v !== exp_v) begin
      fails = fails + 1;
      $display("FAIL cycle_outputs cyc=%0d actual=%h required=%h", cyc, act_v, exp_v);
    end
    cyc = cyc + 1;
    if (pd_valid) c_fwd = c_fwd + 1;
    if (pd_eop && !pd_valid) c_abort = c_abort + 1;
    if (err_len) c_el = c_el + 1;
    if (frame_done) c_fd = c_fd + 1;
    if (err_timeout) begin c_et = c_et + 1; t_to = cyc; end
    if (pd_valid && pd_eop) t_eop = cyc;
  endtask

  task automatic check(input string name, input int act, input int req);
    tests = tests + 1;
    if (act != req) begin
      fails = fails + 1;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cycle_compare();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    in_valid = 0; in_sop = 0; in_eop = 0; res_valid = 0; res_eop = 0;
    repeat (n) step();
  endtask

  task automatic do_reset();
    reset = 1;
    idle(2);
    reset = 0;
  endtask

  // Sends len entries: sop on entry 0 and on sop_at, eop on eop_at.
  task automatic send(input int len, input int eop_at, input int sop_at, input int gap_pct);
    for (int i = 0; i < len; i++) begin
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        in_valid = 0; in_sop = 1'($urandom); in_eop = 1'($urandom);
        step();
      end
      in_valid = 1;
      in_sop = (i == 0) || (i == sop_at);
      in_eop = (i == eop_at);
      in_re = DW'($urandom);
      in_im = DW'($urandom);
      step();
    end
    in_valid = 0; in_sop = 0; in_eop = 0;
  endtask

  task automatic results(input int n, input bit eop_last, input int gap_pct);
    for (int i = 0; i < n; i++) begin
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        res_valid = 0; res_eop = 1'($urandom);
        step();
      end
      res_valid = 1;
      res_eop = eop_last && (i == n - 1);
      step();
    end
    res_valid = 0; res_eop = 0;
  endtask

  int b_fwd, b_abort, b_el, b_fd;

  initial begin
    do_reset();
    check("reset_frame_cnt", int'(frame_cnt), 0);

    // Good batch followed by a complete result record.
    b_fd = c_fd; b_fwd = c_fwd;
    send(BS, BS - 1, -1, 0);
    results(NP, 1, 0);
    idle(2);
    check("good_forwarded", c_fwd - b_fwd, 8);
    check("good_frame_done", c_fd - b_fd, 1);
    check("good_frame_cnt", int'(frame_cnt), 1);
    check("good_busy_low", int'(busy), 0);

    // Back-to-back: second batch dropped while waiting, third accepted.
    do_reset();
    send(BS, BS - 1, -1, 0);
    idle(1);
    b_fwd = c_fwd;
    send(BS, BS - 1, -1, 0);
    check("b2b_nothing_fwd", c_fwd - b_fwd, 0);
    results(NP, 1, 0);
    send(BS, BS - 1, -1, 0);
    results(NP, 1, 0);
    idle(2);
    check("b2b_drop_cnt", int'(drop_cnt), 1);
    check("b2b_frame_cnt", int'(frame_cnt), 2);

    // Short batch: eop on the sixth entry.
    do_reset();
    b_fwd = c_fwd; b_abort = c_abort; b_el = c_el;
    send(6, 5, -1, 0);
    idle(2);
    check("short_forwarded", c_fwd - b_fwd, 5);
    check("short_abort_eop", c_abort - b_abort, 1);
    check("short_err_len", c_el - b_el, 1);
    check("short_frame_cnt", int'(frame_cnt), 0);

    // Long batch: nine entries without eop.
    b_fwd = c_fwd; b_el = c_el;
    send(9, -1, -1, 0);
    idle(2);
    check("long_forwarded", c_fwd - b_fwd, 8);
    check("long_err_len", c_el - b_el, 1);

    // Mid-batch sop on entry 3.
    b_fwd = c_fwd; b_el = c_el;
    send(BS, BS - 1, 3, 0);
    idle(2);
    check("midsop_forwarded", c_fwd - b_fwd, 3);
    check("midsop_err_len", c_el - b_el, 1);
    check("midsop_drop_cnt", int'(drop_cnt), 1);

    // Timeout, then a later batch is accepted.
    do_reset();
    t_to = -1;
    send(BS, BS - 1, -1, 0);
    idle(TMO + 4);
    check("timeout_latency", t_to - t_eop, 16);
    check("timeout_count", c_et, 1);
    send(BS, BS - 1, -1, 0);
    results(NP, 1, 0);
    idle(1);
    check("after_timeout_frame_cnt", int'(frame_cnt), 1);

    // Reset while passing entry 4, then a batch while disabled.
    b_abort = c_abort;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; in_sop = (i == 0); in_eop = 0;
      in_re = DW'($urandom); in_im = DW'($urandom);
      step();
    end
    reset = 1;
    step();
    reset = 0;
    idle(2);
    check("rst_abort_eop", c_abort - b_abort, 0);
    check("rst_flags", int'({pd_valid, pd_sop, pd_eop, busy, frame_done, err_len, err_timeout}), 0);
    check("rst_frame_cnt", int'(frame_cnt), 0);
    check("rst_data", int'({pd_re, pd_im}), 0);
    enable = 0;
    b_fwd = c_fwd;
    send(BS, BS - 1, -1, 0);
    idle(2);
    enable = 1;
    check("disabled_fwd", c_fwd - b_fwd, 0);
    check("disabled_drop_cnt", int'(drop_cnt), 1);

    // Randomized traffic against the model.
    for (int k = 0; k < 250; k++) begin
      enable = ($urandom_range(9) != 0);
      case ($urandom_range(9))
        0, 1, 2, 3: begin
          send(BS, BS - 1, -1, 20);
          if ($urandom_range(3) != 0)
            results($urandom_range(NP + 1, NP - 1), 1, 10);
        end
        4: begin
          int len;
          len = $urandom_range(BS - 1, 1);
          send(len, len - 1, -1, 10);
        end
        5: send(BS + 1 + $urandom_range(2), -1, -1, 10);
        6: send(BS, BS - 1, $urandom_range(BS - 1, 1), 10);
        7: results($urandom_range(6, 1), 1'($urandom), 10);
        8: idle($urandom_range(20, 1));
        default: idle(TMO + 2);
      endcase
    end
    idle(TMO + 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/peak_batch_scheduler.md
Name: peak_batch_scheduler

Overview:
- Front-end sequencer for the shared FFT peak detector.
- Admits one complete FFT batch at a time from the FFT output stream and forwards it to the detector. It then blocks further batches until the detector has returned its full peak record, or until a timeout expires.
- Drops batches that arrive while busy or disabled, and flags malformed batches.
- Provides frame, drop and error status to the control/register layer.

Parameters:
- BATCH_SIZE, 1024, entries per FFT batch.
- DATA_WIDTH, 16, bits per re/im entry.
- NPEAKS, 4, result beats expected from the detector per batch.
- TIMEOUT, 4096, maximum cycles in WAIT before abort.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  high: new batches may be admitted
- in_sop  in  1  first entry of FFT batch
- in_eop  in  1  last entry of FFT batch
- in_valid  in  1  FFT entry valid
- in_re  in  DATA_WIDTH  real part, Q<DATA_WIDTH>.0 signed
- in_im  in  DATA_WIDTH  imaginary part, Q<DATA_WIDTH>.0 signed
- pd_sop  out  1  to detector sink_sop
- pd_eop  out  1  to detector sink_eop
- pd_valid  out  1  to detector sink_valid
- pd_re  out  DATA_WIDTH  to detector sink_re
- pd_im  out  DATA_WIDTH  to detector sink_im
- res_valid  in  1  detector source_valid
- res_eop  in  1  detector source_eop
- busy  out  1  high in PASS or WAIT
- frame_done  out  1  one-cycle pulse: good result record completed
- err_len  out  1  one-cycle pulse: malformed batch aborted
- err_timeout  out  1  one-cycle pulse: detector result timeout
- frame_cnt  out  16  completed frames, saturating
- drop_cnt  out  16  dropped batches, saturating

Behaviour:
- Reset (clk edge with reset=1) from any state:
  - state=IDLE.
  - All pd_* outputs, busy and pulses go to 0.
  - frame_cnt, drop_cnt, sample and beat counters and the timer go to 0.
  - No pd_eop is emitted on reset; the detector shares the same reset.
- pd_* are registered copies of in_*: latency exactly 1 cycle for forwarded entries. When not forwarding, pd_valid=pd_sop=pd_eop=0 and pd_re/pd_im hold their last value.
- Sample counter width is clog2(BATCH_SIZE)+2 bits and counts forwarded valid entries in the current batch.
- IDLE:
  - in_valid&&in_sop&&enable: forward entry, cnt=1, go PASS.
  - If in_eop is also set, the batch has length 1: this is good only if BATCH_SIZE==1, in which case go WAIT directly; otherwise apply the abort rule below.
  - in_valid&&in_sop&&!enable: drop_cnt++ and enter skip mode; entries are discarded until in_eop.
  - Valid entries without in_sop are ignored.
- PASS:
  - Each in_valid entry is forwarded, cnt++. in_valid=0 cycles are gaps: nothing forwarded, no timeout applies.
  - in_eop with cnt+1==BATCH_SIZE: forward with pd_eop=1, go WAIT, timer=0, beats=0.
  - Abort conditions:
    - in_eop with wrong count;
    - in_sop while in PASS;
    - cnt reaching BATCH_SIZE with no in_eop on that entry.
  - Abort action: emit one cycle with pd_eop=1, pd_valid=0, pd_sop=0 so the detector resets; the offending entry is not forwarded; pulse err_len; go IDLE.
  - An in_sop that caused the abort is not re-admitted; that batch counts as dropped, drop_cnt++.
  - Deasserting enable mid-batch does not abort the batch; the current batch completes normally.
- WAIT:
  - The timer increments every cycle.
  - res_valid increments beats.
  - res_valid&&res_eop with beats+1==NPEAKS: frame_cnt++, frame_done pulse, go IDLE.
  - res_valid&&res_eop with any other count: err_len pulse, go IDLE.
  - timer==TIMEOUT-1 without res_eop: err_timeout pulse, go IDLE.
  - If res_eop and the timeout coincide, res_eop wins.
  - Any in_valid&&in_sop in WAIT: drop_cnt++, batch skipped until in_eop.
  - The first IDLE cycle may accept a new in_sop.
- res_valid outside WAIT is ignored.
- Both counters saturate at 16'hFFFF and do not wrap.
- busy=1 exactly while state is PASS or WAIT; it is registered together with the state.

Test Plan:
- Good batch: BATCH_SIZE=8, NPEAKS=4, enable=1, 8 contiguous entries, sop on 0 and eop on 7 -> pd_* mirror in_* 1 cycle late; then 4 res_valid beats with eop on the 4th -> frame_done pulses once, frame_cnt=1, busy falls the next cycle.
- Back-to-back: second batch's sop arrives 2 cycles after the first eop while in WAIT -> nothing forwarded, drop_cnt=1; a third batch sent after frame_done is forwarded, frame_cnt=2.
- Short batch: eop on entry 5 of 8 -> no 6th entry forwarded; one cycle with pd_eop=1, pd_valid=0; err_len pulse; state IDLE; frame_cnt unchanged.
- Long batch / mid-batch sop: 9 entries without eop, and separately a sop at entry 3 -> abort on entry 9 and on entry 3 respectively, err_len pulse; in the sop case drop_cnt increments.
- Timeout: TIMEOUT=16, no res_valid after a good batch -> err_timeout pulses exactly 16 cycles after entry to WAIT; a later batch is accepted.
- Reset in PASS at entry 4, plus enable=0 at a sop -> after reset all outputs and counters are 0 with no pd_eop emitted; the batch arriving while disabled increments drop_cnt and none of its entries reach pd_*.
